// File: rtl/i2c_lut_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_lut_sequencer
//
// Purpose:
//   Walks a combinational register-configuration LUT from index 0 to
//   i2c_config_size-1 and issues one 3-byte I2C write per entry
//   ({slave_addr, reg_addr, reg_data}). It drives open-drain SCL/SDA, checks
//   the ACK after every byte and raises a sticky done flag once the last
//   entry's STOP has gone out.
//
// Ports:
//   clk               system clock
//   rst_n             asynchronous active-low reset
//   i2c_config_size   number of LUT entries (static after reset)
//   i2c_config_index  LUT address driven to the config LUT
//   i2c_config_data   LUT output for the current index (combinational)
//   i2c_sclk          SCL, 1 = released
//   i2c_sdat_out      SDA drive value, constant 0
//   i2c_sdat_oe       1 = pull SDA low, 0 = release
//   i2c_sdat_in       SDA pin sample (already synchronised outside)
//   i2c_config_done   sticky, set after the last entry completes
//   i2c_ack_err       sticky, set on any unrecovered NACK
//   i2c_err_cnt       entries abandoned on NACK, saturating at 255
//
// Build option:
//   I2C_NACK_RETRY_EN  when defined, an entry that NACKs is re-sent up to
//                      MAX_RETRY more times before it is counted as failed.
// ---------------------------------------------------------------------------
module i2c_lut_sequencer #(
  parameter int unsigned CLK_FREQ   = 27_000_000,
  parameter int unsigned I2C_FREQ   = 100_000,
  parameter int unsigned INIT_DELAY = 270_000,
  parameter int unsigned GAP_CYCLES = 2_700,
  parameter int unsigned INDEX_W    = 9,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] i2c_config_size,
  output logic [INDEX_W-1:0] i2c_config_index,
  input  logic [23:0]        i2c_config_data,
  output logic               i2c_sclk,
  output logic               i2c_sdat_out,
  output logic               i2c_sdat_oe,
  input  logic               i2c_sdat_in,
  output logic               i2c_config_done,
  output logic               i2c_ack_err,
  output logic [7:0]         i2c_err_cnt
);

  localparam int unsigned QDIV    = CLK_FREQ / (4 * I2C_FREQ);
  localparam int unsigned QCNT_W  = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int unsigned DLY_MAX = (INIT_DELAY > GAP_CYCLES) ? INIT_DELAY : GAP_CYCLES;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 2);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);
`ifdef I2C_NACK_RETRY_EN
  localparam int unsigned RETRY_LIMIT = MAX_RETRY;
`else
  // No re-sends: the first NACK on an entry is final.
  localparam int unsigned RETRY_LIMIT = 0;
`endif

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_BYTE  = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5,
    ST_GAP   = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  state_t             state_q, state_d;
  logic [QCNT_W-1:0]  qcnt_q, qcnt_d;
  logic [1:0]         qph_q, qph_d;       // quarter currently in progress
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [23:0]        sh_q, sh_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               fail_q, fail_d;     // current attempt was NACKed
  logic               scl_q, scl_d;
  logic               oe_q, oe_d;
  logic               done_q, done_d;
  logic               ack_err_q, ack_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               q_tick;
  logic [4:0]         nxt_bit_idx;
  logic [INDEX_W-1:0] last_idx;

  assign q_tick      = (qcnt_q == QCNT_W'(QDIV - 1));
  // The byte on the wire is always sh[23:16]; the next bit below the current one.
  assign nxt_bit_idx = 5'd15 + {2'b00, bit_cnt_q};
  assign last_idx    = i2c_config_size - INDEX_W'(1);

  // Quarter-bit timebase; restarted in LOAD so every frame begins on a full quarter.
  always_comb begin
    qcnt_d = qcnt_q;
    if (state_q == ST_LOAD) begin
      qcnt_d = {QCNT_W{1'b0}};
    end else if (q_tick) begin
      qcnt_d = {QCNT_W{1'b0}};
    end else begin
      qcnt_d = qcnt_q + QCNT_W'(1);
    end
  end

  // Sequencer next-state and bus-drive logic; bus changes happen only on q_tick.
  always_comb begin
    state_d    = state_q;
    qph_d      = qph_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    dly_d      = dly_q;
    index_d    = index_q;
    retry_d    = retry_q;
    fail_d     = fail_q;
    scl_d      = scl_q;
    oe_d       = oe_q;
    done_d     = done_q;
    ack_err_d  = ack_err_q;
    err_cnt_d  = err_cnt_q;

    case (state_q)
      ST_INIT: begin
        if (dly_q == DLY_W'(INIT_DELAY)) begin
          dly_d = {DLY_W{1'b0}};
          if (i2c_config_size == {INDEX_W{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      ST_LOAD: begin
        sh_d       = i2c_config_data;
        byte_cnt_d = 2'd0;
        fail_d     = 1'b0;
        qph_d      = 2'd0;
        state_d    = ST_START;
      end

      // Quarter 0: bus idle; quarter 1: SDA low with SCL high.
      ST_START: begin
        if (q_tick) begin
          if (qph_q == 2'd0) begin
            qph_d = 2'd1;
            oe_d  = 1'b1;
          end else begin
            state_d   = ST_BYTE;
            qph_d     = 2'd0;
            bit_cnt_d = 3'd7;
            scl_d     = 1'b0;
            oe_d      = ~sh_q[23];
          end
        end else begin
          qph_d = qph_q;
        end
      end

      ST_BYTE: begin
        if (q_tick) begin
          case (qph_q)
            2'd0: begin
              scl_d = 1'b1;
              qph_d = 2'd1;
            end
            2'd1: begin
              qph_d = 2'd2;
            end
            2'd2: begin
              scl_d = 1'b0;
              qph_d = 2'd3;
            end
            2'd3: begin
              qph_d = 2'd0;
              if (bit_cnt_q == 3'd0) begin
                state_d = ST_ACK;
                oe_d    = 1'b0;
              end else begin
                bit_cnt_d = bit_cnt_q - 3'd1;
                oe_d      = ~sh_q[nxt_bit_idx];
              end
            end
            default: begin
              qph_d = 2'd0;
            end
          endcase
        end else begin
          qph_d = qph_q;
        end
      end

      // SDA released for the whole bit; the slave's answer is taken at the end of q2.
      ST_ACK: begin
        if (q_tick) begin
          case (qph_q)
            2'd0: begin
              scl_d = 1'b1;
              qph_d = 2'd1;
            end
            2'd1: begin
              qph_d = 2'd2;
            end
            2'd2: begin
              fail_d = i2c_sdat_in;
              scl_d  = 1'b0;
              qph_d  = 2'd3;
            end
            2'd3: begin
              qph_d = 2'd0;
              if (!fail_q && (byte_cnt_q < 2'd2)) begin
                sh_d       = {sh_q[15:0], 8'h00};
                byte_cnt_d = byte_cnt_q + 2'd1;
                bit_cnt_d  = 3'd7;
                oe_d       = ~sh_q[15];
                state_d    = ST_BYTE;
              end else begin
                // Last byte done, or NACK: the rest of the entry is dropped.
                oe_d    = 1'b1;
                state_d = ST_STOP;
              end
            end
            default: begin
              qph_d = 2'd0;
            end
          endcase
        end else begin
          qph_d = qph_q;
        end
      end

      // q0: SCL low / SDA low, q1: SCL high, q2: SDA released.
      ST_STOP: begin
        if (q_tick) begin
          case (qph_q)
            2'd0: begin
              scl_d = 1'b1;
              qph_d = 2'd1;
            end
            2'd1: begin
              oe_d  = 1'b0;
              qph_d = 2'd2;
            end
            default: begin
              qph_d   = 2'd0;
              dly_d   = {DLY_W{1'b0}};
              state_d = ST_GAP;
            end
          endcase
        end else begin
          qph_d = qph_q;
        end
      end

      ST_GAP: begin
        if (dly_q == DLY_W'(GAP_CYCLES)) begin
          dly_d = {DLY_W{1'b0}};
          if (fail_q && (retry_q < RETRY_W'(RETRY_LIMIT))) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ST_LOAD;
          end else begin
            if (fail_q) begin
              ack_err_d = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end else begin
                err_cnt_d = err_cnt_q;
              end
            end else begin
              ack_err_d = ack_err_q;
            end
            retry_d = {RETRY_W{1'b0}};
            if (index_q == last_idx) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              index_d = index_q + INDEX_W'(1);
              state_d = ST_LOAD;
            end
          end
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      ST_DONE: begin
        scl_d  = 1'b1;
        oe_d   = 1'b0;
        done_d = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and output registers; reset releases the bus and restarts from INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      qcnt_q     <= {QCNT_W{1'b0}};
      qph_q      <= 2'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      sh_q       <= 24'h000000;
      dly_q      <= {DLY_W{1'b0}};
      index_q    <= {INDEX_W{1'b0}};
      retry_q    <= {RETRY_W{1'b0}};
      fail_q     <= 1'b0;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      qph_q      <= qph_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      dly_q      <= dly_d;
      index_q    <= index_d;
      retry_q    <= retry_d;
      fail_q     <= fail_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign i2c_config_index = index_q;
  assign i2c_sclk         = scl_q;
  assign i2c_sdat_out     = 1'b0;
  assign i2c_sdat_oe      = oe_q;
  assign i2c_config_done  = done_q;
  assign i2c_ack_err      = ack_err_q;
  assign i2c_err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_i2c_lut_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_lut_sequencer
//
// Bench for i2c_lut_sequencer. A bus monitor/slave decodes START, bytes and
// STOP from the open-drain lines and answers ACK/NACK according to a per-frame
// plan. A reference model derives the expected frame list and error status
// from the LUT contents and the slave's plan.
// ---------------------------------------------------------------------------
module tb_i2c_lut_sequencer;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int I2C_FREQ   = 100_000;
  localparam int INIT_DELAY = 20;
  localparam int GAP_CYCLES = 8;
  localparam int INDEX_W    = 9;
  localparam int MAX_RETRY  = 3;
  localparam int QUARTER    = CLK_FREQ / (4 * I2C_FREQ);

`ifdef I2C_NACK_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [INDEX_W-1:0] cfg_size;
  logic [INDEX_W-1:0] cfg_index;
  logic [23:0]        cfg_data;
  logic               sclk, sdat_out, sdat_oe, sdat_in;
  logic               cfg_done, ack_err;
  logic [7:0]         err_cnt;

  logic [23:0] lut [0:15];
  int          plan [0:63];      // per frame: byte position to NACK, 3 = none
  logic [7:0]  nack_addr;        // address the slave always refuses

  int n_tests = 0;
  int n_fail  = 0;

  // monitor / slave state
  bit          mon_clear = 1'b1;
  bit          slave_low = 1'b0;
  bit          prev_scl, prev_sda, in_frame, hi_valid, lo_valid, first_fall;
  int          cyc, starts, falls, bitc, nbytes;
  int          t_rise, t_fall, hi_meas, hi_bad, lo_meas, lo_bad;
  logic [7:0]  shreg;
  logic [31:0] cur_fr;
  logic [31:0] obs_frames [$];

  // reference model results
  logic [31:0] exp_frames [$];
  int          exp_err;
  bit          exp_aerr;

  i2c_lut_sequencer #(
    .CLK_FREQ  (CLK_FREQ),
    .I2C_FREQ  (I2C_FREQ),
    .INIT_DELAY(INIT_DELAY),
    .GAP_CYCLES(GAP_CYCLES),
    .INDEX_W   (INDEX_W),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i2c_config_size (cfg_size),
    .i2c_config_index(cfg_index),
    .i2c_config_data (cfg_data),
    .i2c_sclk        (sclk),
    .i2c_sdat_out    (sdat_out),
    .i2c_sdat_oe     (sdat_oe),
    .i2c_sdat_in     (sdat_in),
    .i2c_config_done (cfg_done),
    .i2c_ack_err     (ack_err),
    .i2c_err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  assign cfg_data = (cfg_index < 9'd16) ? lut[cfg_index[3:0]] : 24'h000000;
  assign sdat_in  = !(sdat_oe || slave_low);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave answer rule: refuse nack_addr as address byte, plus planned NACKs.
  function automatic bit slave_nacks(input int fidx, input int pos, input logic [7:0] b);
    bit by_plan;
    by_plan = (fidx >= 0) && (fidx < 64) && (plan[fidx] == pos);
    return ((pos == 0) && (b == nack_addr)) || by_plan;
  endfunction

  // Bus monitor and slave, sampled on the falling clock edge.
  always @(negedge clk) begin
    bit scl_n, sda_n;
    scl_n = sclk;
    sda_n = !(sdat_oe || slave_low);
    cyc++;
    if (mon_clear) begin
      slave_low = 1'b0; in_frame = 1'b0; hi_valid = 1'b0; lo_valid = 1'b0;
      first_fall = 1'b0; starts = 0; falls = 0; bitc = 0; nbytes = 0;
      hi_meas = 0; hi_bad = 0; lo_meas = 0; lo_bad = 0; shreg = 8'h00;
      cur_fr = 32'h0; obs_frames.delete();
      scl_n = 1'b1; sda_n = 1'b1;
    end else begin
      if (prev_scl && scl_n && prev_sda && !sda_n) begin
        in_frame = 1'b1; bitc = 0; nbytes = 0; cur_fr = 32'h0;
        first_fall = 1'b1; hi_valid = 1'b0; starts++;
      end else if (prev_scl && scl_n && !prev_sda && sda_n) begin
        if (in_frame) obs_frames.push_back(cur_fr);
        in_frame = 1'b0; hi_valid = 1'b0;
      end
      if (!prev_scl && scl_n) begin
        if (lo_valid) begin
          lo_meas++;
          if (cyc - t_fall != 2 * QUARTER) lo_bad++;
        end
        t_rise = cyc; hi_valid = 1'b1;
        if (in_frame && bitc < 8) shreg = {shreg[6:0], sda_n};
      end
      if (prev_scl && !scl_n) begin
        falls++;
        if (hi_valid) begin
          hi_meas++;
          if (cyc - t_rise != 2 * QUARTER) hi_bad++;
        end
        t_fall = cyc;
        lo_valid = !first_fall;
        if (in_frame && !first_fall) begin
          if (bitc == 7) begin
            bitc = 8;
            if (nbytes < 3) begin
              cur_fr[23 - 8 * nbytes -: 8] = shreg;
              cur_fr[31:24] = 8'(nbytes + 1);
            end
            slave_low = !slave_nacks(starts - 1, nbytes, shreg);
            nbytes++;
          end else if (bitc == 8) begin
            slave_low = 1'b0;
            bitc = 0;
          end else begin
            bitc++;
          end
        end
        first_fall = 1'b0;
      end
    end
    prev_scl = scl_n;
    prev_sda = sda_n;
  end

  // Expected frames: each attempt sends bytes until the first refused one.
  task automatic build_expected();
    int f, attempts, p;
    bit ok;
    logic [7:0]  b;
    logic [31:0] fr;
    exp_frames.delete();
    exp_err = 0; exp_aerr = 1'b0; f = 0;
    attempts = RETRY_EN ? MAX_RETRY + 1 : 1;
    for (int e = 0; e < int'(cfg_size); e++) begin
      ok = 1'b0;
      for (int a = 0; a < attempts && !ok; a++) begin
        fr = 32'h0; p = 3;
        for (int k = 0; k < 3 && p == 3; k++) begin
          b = 8'(lut[e] >> (16 - 8 * k));
          fr[23 - 8 * k -: 8] = b;
          fr[31:24] = 8'(k + 1);
          if (slave_nacks(f, k, b)) p = k;
        end
        exp_frames.push_back(fr);
        f++;
        ok = (p == 3);
      end
      if (!ok) begin
        exp_aerr = 1'b1;
        if (exp_err < 255) exp_err++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mon_clear = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mon_clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int budget;
    budget = 520 * (exp_frames.size() + 1) + INIT_DELAY + 200;
    for (int c = 0; c < budget && !cfg_done; c++) @(negedge clk);
    check({name, ".done"}, 32'(cfg_done), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic compare(input string name);
    int n;
    logic [31:0] exp_idx;
    exp_idx = (cfg_size == 9'd0) ? 32'd0 : 32'(cfg_size - 9'd1);
    check({name, ".frames"}, 32'(obs_frames.size()), 32'(exp_frames.size()));
    check({name, ".starts"}, 32'(starts), 32'(exp_frames.size()));
    n = (obs_frames.size() < exp_frames.size()) ? obs_frames.size() : exp_frames.size();
    for (int i = 0; i < n; i++) check($sformatf("%s.frame%0d", name, i), obs_frames[i], exp_frames[i]);
    check({name, ".ack_err"}, 32'(ack_err), 32'(exp_aerr));
    check({name, ".err_cnt"}, 32'(err_cnt), 32'(exp_err));
    check({name, ".index"},   32'(cfg_index), exp_idx);
    check({name, ".idle"},    {30'd0, sclk, sdat_oe}, 32'd2);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 64; i++) plan[i] = 3;
    nack_addr = 8'hFF;
  endtask

  task automatic load_basic();
    lut[0] = 24'h98F480; lut[1] = 24'h98F57C; lut[2] = 24'h44BA01;
  endtask

  initial begin
    int cnt6c;
    bit hit;
    for (int i = 0; i < 16; i++) lut[i] = 24'h000000;
    clear_plan();
    load_basic();
    cfg_size = 9'd3;

    // reset values
    repeat (3) @(negedge clk);
    check("rst.scl", 32'(sclk), 32'd1);
    check("rst.oe", 32'(sdat_oe), 32'd0);
    check("rst.sdo", 32'(sdat_out), 32'd0);
    check("rst.index", 32'(cfg_index), 32'd0);
    check("rst.done", 32'(cfg_done), 32'd0);
    check("rst.ack_err", 32'(ack_err), 32'd0);
    check("rst.err_cnt", 32'(err_cnt), 32'd0);

    // basic three-entry run plus SCL timing
    build_expected(); do_reset(); wait_done("basic"); compare("basic");
    check("basic.hi_meas", 32'(hi_meas > 0), 32'd1);
    check("basic.lo_meas", 32'(lo_meas > 0), 32'd1);
    check("basic.hi_bad", 32'(hi_bad), 32'd0);
    check("basic.lo_bad", 32'(lo_bad), 32'd0);

    // entry 1 address refused once
    clear_plan(); plan[1] = 0;
    build_expected(); do_reset(); wait_done("nack1"); compare("nack1");
    check("nack1.count", 32'(obs_frames.size()), RETRY_EN ? 32'd4 : 32'd3);
    check("nack1.err", 32'(err_cnt), RETRY_EN ? 32'd0 : 32'd1);

    // slave always refuses 0x6C, entries 1 and 2 use it
    clear_plan(); nack_addr = 8'h6C;
    lut[0] = 24'h98F480; lut[1] = 24'h6C1122; lut[2] = 24'h6C3344; lut[3] = 24'h44BA01;
    cfg_size = 9'd4;
    build_expected(); do_reset(); wait_done("n6c"); compare("n6c");
    cnt6c = 0;
    foreach (obs_frames[i]) if (obs_frames[i][23:16] == 8'h6C) cnt6c++;
    check("n6c.attempts", 32'(cnt6c), RETRY_EN ? 32'd8 : 32'd2);
    check("n6c.err", 32'(err_cnt), 32'd2);
    check("n6c.ack_err", 32'(ack_err), 32'd1);

    // randomized LUTs and NACK plans
    for (int r = 0; r < 6; r++) begin
      clear_plan();
      cfg_size = 9'($urandom_range(1, 4));
      for (int i = 0; i < 4; i++) lut[i] = {7'($urandom), 1'b0, 16'($urandom)};
      for (int i = 0; i < 64; i++) if ($urandom_range(0, 4) == 0) plan[i] = $urandom_range(0, 2);
      build_expected(); do_reset(); wait_done($sformatf("rnd%0d", r)); compare($sformatf("rnd%0d", r));
    end

    // empty LUT: straight to done
    clear_plan(); cfg_size = 9'd0;
    build_expected(); do_reset();
    repeat (INIT_DELAY) @(posedge clk);
    @(negedge clk);
    check("size0.done_early", 32'(cfg_done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("size0.done", 32'(cfg_done), 32'd1);
    check("size0.falls", 32'(falls), 32'd0);
    check("size0.index", 32'(cfg_index), 32'd0);

    // reset in the data byte of entry 1
    clear_plan(); load_basic(); cfg_size = 9'd3;
    build_expected(); do_reset();
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      hit = (obs_frames.size() == 1) && in_frame && (nbytes == 2) && (bitc >= 2);
    end
    check("mid.reach", 32'(hit), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.scl", 32'(sclk), 32'd1);
    check("mid.oe", 32'(sdat_oe), 32'd0);
    mon_clear = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mon_clear = 1'b0;
    repeat (INIT_DELAY) @(negedge clk);
    check("mid.init_quiet", 32'(falls), 32'd0);
    check("mid.init_index", 32'(cfg_index), 32'd0);
    wait_done("mid"); compare("mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
